// File: rtl/bit_diff_fsmd_mb.sv
// bit_diff_fsmd_mb
//
// Purpose:
//   FSMD that scans a WIDTH-bit word LANES bits per cycle and reports the
//   signed difference between its one-bits and zero-bits:
//     mode = 0 : ones  - zeros
//     mode = 1 : zeros - ones
//   A job is requested with go while idle (START or DONE). It then runs for
//   exactly WIDTH/LANES COMPUTE cycles, after which the result is published
//   and done rises.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   go     in   1      start request, honoured in START/DONE only
//   mode   in   1      difference direction, latched together with go
//   data   in   WIDTH  word to evaluate, captured every idle cycle
//   abort  in   1      (only with BIT_DIFF_ABORT_EN) drop the running job
//   result out  RW     signed result of the last completed job
//   done   out  1      result valid and no job running
//   busy   out  1      high while in COMPUTE
//
// Configuration:
//   BIT_DIFF_ABORT_EN  when defined, adds the abort input. abort is acted on
//                      only in COMPUTE: the job is dropped, the state returns
//                      to START and the previous result is kept.

module bit_diff_fsmd_mb #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  go,
  input  logic                                  mode,
  input  logic [WIDTH-1:0]                      data,
`ifdef BIT_DIFF_ABORT_EN
  input  logic                                  abort,
`endif
  output logic signed [$clog2(2*WIDTH+1)-1:0]   result,
  output logic                                  done,
  output logic                                  busy
);

  localparam int RW     = $clog2(2*WIDTH+1);
  localparam int NCHUNK = WIDTH / LANES;
  localparam int CW     = ($clog2(NCHUNK) > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(NCHUNK - 1);

  if (WIDTH < 2 || LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : gBadParams
    $fatal(1, "bit_diff_fsmd_mb: illegal WIDTH=%0d / LANES=%0d", WIDTH, LANES);
  end

  typedef enum logic [1:0] {
    START   = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [CW-1:0]          count_q, count_d;
  logic signed [RW-1:0]   diff_q, diff_d;
  logic signed [RW-1:0]   result_q, result_d;
  logic                   mode_q, mode_d;

  logic [RW-1:0]          pop;
  logic signed [RW-1:0]   chunkVal;
  logic signed [RW-1:0]   sumVal;
  logic                   abortHit;

`ifdef BIT_DIFF_ABORT_EN
  assign abortHit = abort;
`else
  assign abortHit = 1'b0;
`endif

  // Popcount of the lane bits about to be consumed this cycle.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + RW'(data_q[i]);
    end
  end

  // Each chunk contributes (ones - zeros) = 2*popcount - LANES.
  assign chunkVal = $signed(pop << 1) - $signed(RW'(LANES));
  assign sumVal   = diff_q + chunkVal;

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    count_d  = count_q;
    diff_d   = diff_q;
    result_d = result_q;
    mode_d   = mode_q;

    case (state_q)
      START, DONE: begin
        // Idle: keep sampling data so the word present at the go edge is used.
        data_d  = data;
        count_d = '0;
        diff_d  = '0;
        if (go) begin
          state_d = COMPUTE;
          mode_d  = mode;
        end
      end

      COMPUTE: begin
        if (abortHit) begin
          state_d = START;
        end else begin
          diff_d  = sumVal;
          data_d  = data_q >> LANES;
          count_d = count_q + CW'(1);
          // Terminal test on the current count so the last chunk is included.
          if (count_q == LAST_COUNT) begin
            state_d  = DONE;
            result_d = mode_q ? -sumVal : sumVal;
          end
        end
      end

      default: begin
        state_d = state_t'('x);
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= START;
      data_q   <= '0;
      count_q  <= '0;
      diff_q   <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      result_q <= result_d;
      mode_q   <= mode_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == COMPUTE);

endmodule

// File: tb/tb_bit_diff_fsmd_mb.sv
// Testbench for bit_diff_fsmd_mb.
// Two instances share clock and reset: dutA (WIDTH=8, LANES=2) and
// dutB (WIDTH=8, LANES=1). Expected results come from a plain count of
// ones and zeros in the captured word.

module tb_bit_diff_fsmd_mb;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst;

  logic goA, modeA;
  logic [7:0] dataA;
  logic signed [RW-1:0] resultA;
  logic doneA, busyA;

  logic goB, modeB;
  logic [7:0] dataB;
  logic signed [RW-1:0] resultB;
  logic doneB, busyB;

`ifdef BIT_DIFF_ABORT_EN
  logic abortA, abortB;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_diff_fsmd_mb #(.WIDTH(8), .LANES(2)) dutA (
    .clk    (clk),
    .rst    (rst),
    .go     (goA),
    .mode   (modeA),
    .data   (dataA),
`ifdef BIT_DIFF_ABORT_EN
    .abort  (abortA),
`endif
    .result (resultA),
    .done   (doneA),
    .busy   (busyA)
  );

  bit_diff_fsmd_mb #(.WIDTH(8), .LANES(1)) dutB (
    .clk    (clk),
    .rst    (rst),
    .go     (goB),
    .mode   (modeB),
    .data   (dataB),
`ifdef BIT_DIFF_ABORT_EN
    .abort  (abortB),
`endif
    .result (resultB),
    .done   (doneB),
    .busy   (busyB)
  );

  // Reference: ones minus zeros of the word, negated for mode 1.
  function automatic logic signed [RW-1:0] refDiff(input logic [7:0] d, input logic m);
    int ones;
    int r;
    ones = $countones(d);
    r = ones - (8 - ones);
    if (m) r = -r;
    return RW'(r);
  endfunction

  // Pulse go for one edge with the given word and mode (sel 0 = A, 1 = B).
  task automatic startJob(input bit sel, input logic [7:0] d, input logic m);
    @(negedge clk);
    if (sel) begin dataB = d; modeB = m; goB = 1'b1; end
    else     begin dataA = d; modeA = m; goA = 1'b1; end
    @(negedge clk);
    goA = 1'b0;
    goB = 1'b0;
  endtask

  // Count negedges with busy high, bounded; optionally scramble inputs meanwhile.
  task automatic waitIdle(input bit sel, input bit scramble, output int cycles);
    cycles = 0;
    while ((sel ? busyB : busyA) && cycles < 40) begin
      if (scramble) begin
        if (sel) begin dataB = 8'($urandom); modeB = 1'($urandom); end
        else     begin dataA = 8'($urandom); modeA = 1'($urandom); end
      end
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (resultA !== 5'sd0) begin errors++; $display("[TB] FAIL reset_resultA: got %0d expected 0", resultA); end
    checks++; if (doneA !== 1'b0)    begin errors++; $display("[TB] FAIL reset_doneA: got %b expected 0", doneA); end
    checks++; if (busyA !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busyA: got %b expected 0", busyA); end
    checks++; if (doneB !== 1'b0 || busyB !== 1'b0 || resultB !== 5'sd0) begin
      errors++; $display("[TB] FAIL reset_B: got done=%b busy=%b result=%0d expected 0/0/0", doneB, busyB, resultB);
    end
    rst = 1'b0;
  endtask

  task automatic test_ones();
    int cyc;
    startJob(0, 8'hFF, 1'b0);
    waitIdle(0, 0, cyc);
    checks++; if (cyc !== 4)        begin errors++; $display("[TB] FAIL ones_busy_cycles: got %0d expected 4", cyc); end
    checks++; if (doneA !== 1'b1)   begin errors++; $display("[TB] FAIL ones_done: got %b expected 1", doneA); end
    checks++; if (resultA !== 5'sd8) begin errors++; $display("[TB] FAIL ones_result: got %0d expected 8", resultA); end
  endtask

  task automatic test_zeros();
    int cyc;
    startJob(0, 8'h00, 1'b0);
    waitIdle(0, 0, cyc);
    checks++; if (resultA !== -5'sd8) begin errors++; $display("[TB] FAIL zeros_mode0: got %0d expected -8", resultA); end
    startJob(0, 8'h00, 1'b1);
    waitIdle(0, 0, cyc);
    checks++; if (resultA !== 5'sd8) begin errors++; $display("[TB] FAIL zeros_mode1: got %0d expected 8", resultA); end
    checks++; if (doneA !== 1'b1)    begin errors++; $display("[TB] FAIL zeros_done: got %b expected 1", doneA); end
  endtask

  task automatic test_lanes1();
    int cyc;
    startJob(1, 8'h07, 1'b0);
    waitIdle(1, 0, cyc);
    checks++; if (cyc !== 8)          begin errors++; $display("[TB] FAIL lanes1_busy_cycles: got %0d expected 8", cyc); end
    checks++; if (resultB !== -5'sd2) begin errors++; $display("[TB] FAIL lanes1_mode0: got %0d expected -2", resultB); end
    startJob(1, 8'h07, 1'b1);
    waitIdle(1, 0, cyc);
    checks++; if (resultB !== 5'sd2 || doneB !== 1'b1) begin
      errors++; $display("[TB] FAIL lanes1_mode1: got result=%0d done=%b expected 2/1", resultB, doneB);
    end
  endtask

  task automatic test_ignore_inputs();
    int cyc;
    @(negedge clk);
    dataA = 8'hA5; modeA = 1'b0; goA = 1'b1;
    @(negedge clk);
    dataA = 8'hFF; modeA = 1'b1;
    checks++; if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL ignore_done_low: got %b expected 0", doneA); end
    waitIdle(0, 0, cyc);
    checks++; if (cyc !== 4)          begin errors++; $display("[TB] FAIL ignore_busy_cycles: got %0d expected 4", cyc); end
    checks++; if (resultA !== 5'sd0)  begin errors++; $display("[TB] FAIL ignore_result: got %0d expected 0", resultA); end
    checks++; if (doneA !== 1'b1)     begin errors++; $display("[TB] FAIL ignore_done: got %b expected 1", doneA); end
    @(negedge clk);
    goA = 1'b0;
    checks++; if (busyA !== 1'b1 || doneA !== 1'b0) begin
      errors++; $display("[TB] FAIL ignore_restart: got busy=%b done=%b expected 1/0", busyA, doneA);
    end
    waitIdle(0, 0, cyc);
    checks++; if (resultA !== -5'sd8) begin errors++; $display("[TB] FAIL ignore_second: got %0d expected -8", resultA); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [7:0] d;
    logic m;
    logic signed [RW-1:0] exp;
    d = 8'($urandom); m = 1'($urandom);
    exp = refDiff(d, m);
    @(negedge clk);
    dataA = d; modeA = m; goA = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      waitIdle(0, 1, cyc);
      modeA = m;
      checks++; if (cyc !== 4 || doneA !== 1'b1 || resultA !== exp) begin
        errors++; $display("[TB] FAIL b2b_job%0d: got cycles=%0d done=%b result=%0d expected 4/1/%0d", j, cyc, doneA, resultA, exp);
      end
      d = 8'($urandom); m = 1'($urandom);
      exp = refDiff(d, m);
      dataA = d; modeA = m;
      @(negedge clk);
      checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL b2b_one_done_cycle%0d: got busy=%b expected 1", j, busyA); end
    end
    goA = 1'b0;
    waitIdle(0, 0, cyc);
    checks++; if (resultA !== exp) begin errors++; $display("[TB] FAIL b2b_last: got %0d expected %0d", resultA, exp); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [7:0] d;
    startJob(0, 8'hFF, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busyA !== 1'b0 || doneA !== 1'b0 || resultA !== 5'sd0) begin
      errors++; $display("[TB] FAIL rstmid_immediate: got busy=%b done=%b result=%0d expected 0/0/0", busyA, doneA, resultA);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (doneA !== 1'b0 || resultA !== 5'sd0) begin
      errors++; $display("[TB] FAIL rstmid_after: got done=%b result=%0d expected 0/0", doneA, resultA);
    end
    rst = 1'b1;
    @(negedge clk);
    d = 8'h3C;
    rst = 1'b0; dataA = d; modeA = 1'b1; goA = 1'b1;
    @(negedge clk);
    goA = 1'b0;
    checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_first_go: got busy=%b expected 1", busyA); end
    waitIdle(0, 0, cyc);
    checks++; if (resultA !== refDiff(d, 1'b1) || doneA !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_next_job: got result=%0d done=%b expected %0d/1", resultA, doneA, refDiff(d, 1'b1));
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] d;
    logic m;
    bit sel;
    for (int j = 0; j < 16; j++) begin
      d = 8'($urandom); m = 1'($urandom); sel = 1'($urandom);
      startJob(sel, d, m);
      waitIdle(sel, 1, cyc);
      checks++;
      if (sel) begin
        if (cyc !== 8 || resultB !== refDiff(d, m) || doneB !== 1'b1) begin
          errors++; $display("[TB] FAIL randB_%0d d=%h m=%b: got cycles=%0d result=%0d done=%b expected 8/%0d/1", j, d, m, cyc, resultB, doneB, refDiff(d, m));
        end
      end else begin
        if (cyc !== 4 || resultA !== refDiff(d, m) || doneA !== 1'b1) begin
          errors++; $display("[TB] FAIL randA_%0d d=%h m=%b: got cycles=%0d result=%0d done=%b expected 4/%0d/1", j, d, m, cyc, resultA, doneA, refDiff(d, m));
        end
      end
    end
  endtask

`ifdef BIT_DIFF_ABORT_EN
  task automatic test_abort();
    int cyc;
    startJob(0, 8'hFF, 1'b0);
    waitIdle(0, 0, cyc);
    startJob(0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abortA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    checks++; if (busyA !== 1'b0 || doneA !== 1'b0 || resultA !== 5'sd8) begin
      errors++; $display("[TB] FAIL abort: got busy=%b done=%b result=%0d expected 0/0/8", busyA, doneA, resultA);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    goA = 1'b0; modeA = 1'b0; dataA = '0;
    goB = 1'b0; modeB = 1'b0; dataB = '0;
`ifdef BIT_DIFF_ABORT_EN
    abortA = 1'b0; abortB = 1'b0;
`endif
    $display("[TB] starting");
    test_reset();
    test_ones();
    test_zeros();
    test_lanes1();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef BIT_DIFF_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
